// File: rtl/mem_stage.sv
// Memory stage: serialises loads and stores into byte-wide accesses on an 8-bit
// synchronous memory port, stalling the pipeline until the access completes.
module mem_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        forward,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_val,
  input  logic [6:0]  ins_type,
  input  logic [2:0]  ins_details,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_val,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  output logic        out_forward,
  output logic [4:0]  out_rd_addr,
  output logic [31:0] out_rd_val,
  output logic        stall_req
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state;
  logic [1:0]  k;
  logic [31:0] buffer;
  logic        hold_load;
  logic        hold_forward;
  logic [4:0]  hold_rd_addr;
  logic [31:0] hold_rd_val;
  logic [31:0] hold_addr;
  logic [31:0] hold_val;
  logic [2:0]  hold_funct3;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [7:0]  dout_q;
  logic [7:0]  snap;
  logic        snapped;

  logic        is_load;
  logic        is_store;
  logic [1:0]  k_last;
  logic [1:0]  k_next;
  logic [1:0]  k_prev;
  logic [7:0]  din_byte;
  logic [31:0] load_val;

  assign is_load  = (ins_type == OP_LOAD);
  assign is_store = (ins_type == OP_STORE);
  assign k_last   = hold_funct3[1] ? 2'd3 : {1'b0, hold_funct3[0]};
  assign k_next   = k + 2'd1;
  assign k_prev   = k - 2'd1;
  // The memory answers one cycle after issue even if rdy_in drops, so the
  // first byte seen during a stall is snapshotted and used when rdy_in returns.
  assign din_byte = snapped ? snap : mem_din;

  always_comb begin
    load_val = buffer;
    case (hold_funct3)
      3'b000:  load_val = {{24{buffer[7]}}, buffer[7:0]};
      3'b001:  load_val = {{16{buffer[15]}}, buffer[15:0]};
      3'b100:  load_val = {24'd0, buffer[7:0]};
      3'b101:  load_val = {16'd0, buffer[15:0]};
      default: load_val = buffer;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      k            <= 2'd0;
      buffer       <= 32'd0;
      hold_load    <= 1'b0;
      hold_forward <= 1'b0;
      hold_rd_addr <= 5'd0;
      hold_rd_val  <= 32'd0;
      hold_addr    <= 32'd0;
      hold_val     <= 32'd0;
      hold_funct3  <= 3'd0;
      addr_q       <= 32'd0;
      wr_q         <= 1'b0;
      dout_q       <= 8'd0;
      snap         <= 8'd0;
      snapped      <= 1'b0;
    end else if (!rdy_in) begin
      if (!snapped) begin
        snap    <= mem_din;
        snapped <= 1'b1;
      end
    end else begin
      snapped <= 1'b0;
      case (state)
        IDLE: begin
          if (is_load || is_store) begin
            state        <= ACCESS;
            k            <= 2'd0;
            buffer       <= 32'd0;
            hold_load    <= is_load;
            hold_forward <= forward;
            hold_rd_addr <= rd_addr;
            hold_rd_val  <= rd_val;
            hold_addr    <= mem_addr;
            hold_val     <= mem_val;
            hold_funct3  <= ins_details;
            addr_q       <= mem_addr;
            wr_q         <= is_store;
            dout_q       <= mem_val[7:0];
          end
        end
        ACCESS: begin
          if (hold_load && k != 2'd0)
            buffer[{k_prev, 3'b000} +: 8] <= din_byte;
          if (k == k_last) begin
            state <= hold_load ? WAIT : DONE;
            wr_q  <= 1'b0;
          end else begin
            k      <= k_next;
            addr_q <= hold_addr + {30'd0, k_next};
            wr_q   <= !hold_load;
            dout_q <= hold_val[{k_next, 3'b000} +: 8];
          end
        end
        WAIT: begin
          buffer[{k, 3'b000} +: 8] <= din_byte;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          k     <= 2'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything is forced quiet while reset is asserted, even before the first edge.
  always_comb begin
    mem_a       = 32'd0;
    mem_wr      = 1'b0;
    mem_dout    = 8'd0;
    out_forward = 1'b0;
    out_rd_addr = 5'd0;
    out_rd_val  = 32'd0;
    stall_req   = 1'b0;
    if (!rst_in) begin
      mem_a    = addr_q;
      mem_dout = dout_q;
      mem_wr   = wr_q && rdy_in && (state == ACCESS);
      case (state)
        IDLE: begin
          if (is_load || is_store) begin
            stall_req = 1'b1;
          end else begin
            out_forward = forward;
            out_rd_addr = rd_addr;
            out_rd_val  = rd_val;
          end
        end
        ACCESS, WAIT: stall_req = 1'b1;
        DONE: begin
          out_forward = hold_forward;
          out_rd_addr = hold_rd_addr;
          out_rd_val  = hold_load ? load_val : hold_rd_val;
        end
        default: stall_req = 1'b0;
      endcase
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have: clk_in  input  1  clock; all state updates on the rising edge.
REQ-002 SHALL have: rst_in  input  1  reset; one clock, synchronous, active-high.
REQ-003 SHALL have: rdy_in  input  1  global ready; low freezes all state.
REQ-004 SHALL have: forward, rd_addr[4:0], rd_val[31:0]  inputs  from EX/MEM register  writeback intent, destination, ALU result.
REQ-005 SHALL have: ins_type  input  7  opcode; LOAD=7'b0000011, STORE=7'b0100011.
REQ-006 SHALL have: ins_details  input  3  funct3 (000 byte, 001 half, 010 word; bit2 = unsigned for loads).
REQ-007 SHALL have: mem_addr  input  32  effective byte address.
REQ-008 SHALL have: mem_val  input  32  store data.
REQ-009 SHALL have: mem_din  input  8  memory read byte.
REQ-010 SHALL have: mem_a  output  32  memory byte address.
REQ-011 SHALL have: mem_wr  output  1  write strobe.
REQ-012 SHALL have: mem_dout  output  8  write byte.
REQ-013 SHALL have: out_forward, out_rd_addr[4:0], out_rd_val[31:0]  outputs  to MEM/WB register.
REQ-014 SHALL have: stall_req  output  1  holds EX/MEM and upstream stages while high.

Function
REQ-015 Byte count N SHALL be 1/2/4 for ins_details[1:0] = 00/01/1x.
REQ-016 States SHALL be IDLE, ACCESS (byte index k = 0..N-1), WAIT (load only), DONE.
REQ-017 IDLE, non-memory ins_type: out_* SHALL equal forward/rd_addr/rd_val combinationally; stall_req=0; mem_wr=0.
REQ-018 IDLE, LOAD or STORE: stall_req SHALL be 1 in the same cycle; next edge -> ACCESS with k=0.
REQ-019 stall_req SHALL remain 1 in ACCESS and WAIT and SHALL be 0 in DONE.
REQ-020 ACCESS: mem_a SHALL equal mem_addr+k (mod 2^32, so wrap from 0xFFFFFFFF to 0x0 is legal); misaligned addresses SHALL be handled without special casing.
REQ-021 STORE, ACCESS: mem_wr=1 and mem_dout=mem_val[8k+7:8k]; after k=N-1 -> DONE.
REQ-022 LOAD, ACCESS: mem_wr=0; mem_din sampled in cycle t SHALL be byte k-1 issued in cycle t-1, written to buffer byte k-1; after k=N-1 -> WAIT.
REQ-023 WAIT: last byte SHALL be captured into the buffer; -> DONE.
REQ-024 DONE: out_forward/out_rd_addr SHALL equal the held inputs.
REQ-025 DONE: out_rd_val SHALL be the buffer extended per funct3 (LB sign bit7, LH sign bit15, LBU/LHU zero, LW raw) for loads, and rd_val for stores.
REQ-026 DONE SHALL last exactly one cycle, then -> IDLE; the next instruction SHALL be observed only in IDLE, so no instruction executes twice.
REQ-027 Latency SHALL be N+2 stall cycles for stores and N+3 for loads, DONE included, rdy_in high throughout.
REQ-028 rdy_in=0: state, k and buffer SHALL hold; mem_wr SHALL be forced 0; mem_a SHALL hold its last value.
REQ-029 A load byte issued before a rdy_in-low gap SHALL be captured in the first rdy_in-high cycle after issue.
REQ-030 Outside ACCESS, mem_wr SHALL be 0; memory SHALL never be written twice for the same byte of one store.

Reset
REQ-031 While rst_in=1: state=IDLE, k=0, buffer=0.
REQ-032 While rst_in=1: stall_req=0, mem_wr=0, mem_a=0, mem_dout=0.
REQ-033 While rst_in=1: out_forward=0, out_rd_addr=0, out_rd_val=0.
REQ-034 Reset mid-ACCESS/WAIT SHALL abort the access with no further writes; the first post-reset cycle SHALL be IDLE.

Verification
REQ-035 ADDI, forward=1, rd_addr=5, rd_val=0x1234 -> same cycle: out_rd_val=0x1234, stall_req=0, mem_wr never 1.
REQ-036 SW, mem_addr=0x100, mem_val=0xAABBCCDD -> writes 0xDD@0x100, 0xCC@0x101, 0xBB@0x102, 0xAA@0x103 on consecutive cycles; stall_req high 5 cycles, falls in DONE.
REQ-037 LB, mem_addr=0x20, memory byte 0x80 -> out_rd_val=0xFFFFFF80 in DONE; LBU same byte -> 0x00000080.
REQ-038 LH, mem_addr=0xFFFFFFFF, bytes 0x34@0xFFFFFFFF, 0x92@0x0 -> mem_a sequence 0xFFFFFFFF, 0x0; out_rd_val=0xFFFF9234.
REQ-039 LW with rdy_in=0 for 3 cycles after the byte-1 issue -> no state change, mem_wr=0 throughout; final out_rd_val correct; stall count grows by 3.
REQ-040 SW, rst_in=1 after 2 bytes written -> no writes to bytes 2-3; stall_req=0 during reset; IDLE afterwards.
